// File: rtl/score_pkg.sv
// Shared types and defaults for the score event generator and related game blocks.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        FIRE  = 3'd2,
        HOLD  = 3'd3,
        WON   = 3'd4
    } state_t;

    typedef logic [3:0] count_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned MAX_SCORE_DEF       = 9;

endpackage

// File: rtl/score_event_gen_sync2.sv
// Two-flop synchronizer for asynchronous game inputs; cleared only by reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/score_event_gen.sv
// Debounces the raw eat level into one increment pulse per eat assertion and
// tracks a shadow score that latches win at MAX_SCORE.
module score_event_gen
    import score_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned MAX_SCORE       = MAX_SCORE_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   eat,
    input  logic   clear,
    output logic   increment,
    output logic   win,
    output count_t count
);

    localparam count_t C_DEB = count_t'(DEBOUNCE_CYCLES);
    localparam count_t C_MAX = count_t'(MAX_SCORE);

    logic   w_eat_s;
    state_t r_state;
    state_t w_state_nxt;
    count_t r_dbc;
    count_t w_dbc_nxt;
    count_t r_count;
    count_t w_count_nxt;
    count_t w_count_inc;

    sync2 u_sync_eat (
        .clk   (clk),
        .reset (reset),
        .d     (eat),
        .q     (w_eat_s)
    );

    assign w_count_inc = r_count + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dbc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dbc   <= w_dbc_nxt;
            r_count <= w_count_nxt;
        end
    end

    // clear overrides every transition, including the edge leaving FIRE
    always_comb begin
        w_state_nxt = r_state;
        w_dbc_nxt   = r_dbc;
        w_count_nxt = r_count;
        if (clear) begin
            w_state_nxt = IDLE;
            w_dbc_nxt   = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_eat_s) begin
                        w_state_nxt = ARMED;
                        w_dbc_nxt   = 4'd1;
                    end
                end
                ARMED: begin
                    if (!w_eat_s) begin
                        w_state_nxt = IDLE;
                        w_dbc_nxt   = '0;
                    end else if (r_dbc == C_DEB) begin
                        w_state_nxt = FIRE;
                        w_dbc_nxt   = '0;
                    end else begin
                        w_dbc_nxt = r_dbc + 4'd1;
                    end
                end
                FIRE: begin
                    if (r_count < C_MAX) begin
                        w_count_nxt = w_count_inc;
                    end
                    w_state_nxt = (w_count_inc >= C_MAX) ? WON : HOLD;
                end
                HOLD: begin
                    if (!w_eat_s) begin
                        w_state_nxt = IDLE;
                    end
                end
                WON: begin
                    w_state_nxt = WON;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_dbc_nxt   = '0;
                end
            endcase
        end
    end

    assign increment = (r_state == FIRE);
    assign win       = (r_state == WON);
    assign count     = r_count;

endmodule
